// File: rtl/mux_scan_serializer_pkg.sv
// Shared types and sizing for the mux scan serializer.
// PARITY_EN adds the trailing even-parity beat and its FSM state.
package mux_scan_pkg;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned SEL_W = $clog2(WIDTH);
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(WIDTH - 1);

`ifdef PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} scan_state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT} scan_state_t;
`endif

endpackage

// File: rtl/mux_scan_serializer_if.sv
// Load and serial-stream handshake bundle for mux_scan_serializer.
interface mux_scan_serializer_if;
    import mux_scan_pkg::*;

    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] load_data;
    logic [WIDTH-1:0] din_q;
    logic [SEL_W-1:0] s;
    logic             ser_out;
    logic             ser_valid;
    logic             ser_last;
    logic             ser_ready;

    modport master (
        output load_valid, load_data, ser_ready,
        input  load_ready, din_q, s, ser_out, ser_valid, ser_last
    );

    modport slave (
        input  load_valid, load_data, ser_ready,
        output load_ready, din_q, s, ser_out, ser_valid, ser_last
    );

endinterface

// File: rtl/mux_scan_serializer_sel_mux.sv
// 16:1 bit-select mux, same structure as the downstream mux stage.
module scan_sel_mux
    import mux_scan_pkg::*;
(
    input  logic [WIDTH-1:0] i_data,
    input  logic [SEL_W-1:0] i_sel,
    output logic             o_bit
);

    assign o_bit = i_data[i_sel];

endmodule

// File: rtl/mux_scan_serializer.sv
// Parallel-to-serial driver: holds a word on din_q and steps s 0..15 (LSB first).
// Optional PARITY_EN appends an even-parity beat that carries ser_last.
module mux_scan_serializer
    import mux_scan_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    mux_scan_serializer_if.slave  bus
);

    scan_state_t      r_state;
    scan_state_t      w_state_next;
    logic [WIDTH-1:0] r_din;
    logic [SEL_W-1:0] r_sel;
    logic             w_mux_bit;
    logic             w_load;
    logic             w_step;
    logic             w_final;

    scan_sel_mux u_sel_mux (
        .i_data (r_din),
        .i_sel  (r_sel),
        .o_bit  (w_mux_bit)
    );

    assign w_load  = (r_state == IDLE) && bus.load_valid;
    assign w_final = (r_state == SHIFT) && bus.ser_ready && (r_sel == SEL_LAST);
    assign w_step  = (r_state == SHIFT) && bus.ser_ready && (r_sel != SEL_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // s holds at 15 after the last data beat; it is only cleared by a load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_din <= '0;
            r_sel <= '0;
        end else if (w_load) begin
            r_din <= bus.load_data;
            r_sel <= '0;
        end else if (w_step) begin
            r_sel <= r_sel + 1'b1;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:   if (bus.load_valid) w_state_next = SHIFT;
`ifdef PARITY_EN
            SHIFT:  if (w_final) w_state_next = PARITY;
            PARITY: if (bus.ser_ready) w_state_next = IDLE;
`else
            SHIFT:  if (w_final) w_state_next = IDLE;
`endif
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.load_ready = 1'b0;
        bus.ser_valid  = 1'b0;
        bus.ser_out    = 1'b0;
        bus.ser_last   = 1'b0;
        case (r_state)
            IDLE: bus.load_ready = 1'b1;
            SHIFT: begin
                bus.ser_valid = 1'b1;
                bus.ser_out   = w_mux_bit;
`ifndef PARITY_EN
                bus.ser_last  = (r_sel == SEL_LAST);
`endif
            end
`ifdef PARITY_EN
            PARITY: begin
                bus.ser_valid = 1'b1;
                bus.ser_out   = ^r_din;
                bus.ser_last  = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    assign bus.din_q = r_din;
    assign bus.s     = r_sel;

endmodule

// File: tb/tb_mux_scan_serializer.sv
// Directed bench for mux_scan_serializer; build with +define+PARITY_EN for the parity variant.
module tb_mux_scan_serializer;
    import mux_scan_pkg::*;

`ifdef PARITY_EN
    localparam bit LastOnShift = 1'b0;
`else
    localparam bit LastOnShift = 1'b1;
`endif

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    mux_scan_serializer_if bus ();

    mux_scan_serializer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive the load handshake; returns at the negedge after the word was taken.
    task automatic load_word(input logic [15:0] w);
        bus.load_valid = 1'b1;
        bus.load_data  = w;
        @(negedge clk);
        bus.load_valid = 1'b0;
    endtask

    // Expects the stream to be past its data beats; checks optional parity beat then IDLE.
    task automatic check_tail(input logic [15:0] w, input string tag);
        bus.ser_ready = 1'b1;
`ifdef PARITY_EN
        #1;
        checks++;
        if ({bus.ser_valid, bus.ser_out, bus.ser_last} !== {1'b1, ^w, 1'b1}) begin
            errors++;
            $display("FAIL %s parity beat {valid,out,last} got %b want %b", tag,
                     {bus.ser_valid, bus.ser_out, bus.ser_last}, {1'b1, ^w, 1'b1});
        end
        @(negedge clk);
`endif
        #1;
        checks++;
        if ({bus.load_ready, bus.ser_valid, bus.ser_last} !== 3'b100) begin
            errors++;
            $display("FAIL %s idle after word {load_ready,valid,last} got %b want 100", tag,
                     {bus.load_ready, bus.ser_valid, bus.ser_last});
        end
    endtask

    task automatic stream_word(input logic [15:0] w, input string tag);
        bus.ser_ready = 1'b1;
        load_word(w);
        for (int i = 0; i < 16; i++) begin
            #1;
            checks++;
            if ({bus.ser_valid, bus.ser_out, bus.s, bus.ser_last} !==
                {1'b1, w[i], 4'(i), LastOnShift && (i == 15)}) begin
                errors++;
                $display("FAIL %s beat %0d {valid,out,s,last} got %b want %b", tag, i,
                         {bus.ser_valid, bus.ser_out, bus.s, bus.ser_last},
                         {1'b1, w[i], 4'(i), LastOnShift && (i == 15)});
            end
            @(negedge clk);
        end
        check_tail(w, tag);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.load_valid = 1'b0;
        bus.load_data  = 16'h0;
        bus.ser_ready  = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({bus.load_ready, bus.ser_valid, bus.ser_last, bus.ser_out, bus.s, bus.din_q} !==
            {4'b1000, 4'h0, 16'h0}) begin
            errors++;
            $display("FAIL reset state got %h want %h",
                     {bus.load_ready, bus.ser_valid, bus.ser_last, bus.ser_out, bus.s, bus.din_q},
                     {4'b1000, 4'h0, 16'h0});
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // A5C3 LSB first: 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1
    task automatic test_basic_stream();
        logic [15:0] exp_bits;
        exp_bits = 16'b1010_0101_1100_0011;
        bus.ser_ready = 1'b1;
        load_word(16'hA5C3);
        for (int i = 0; i < 16; i++) begin
            #1;
            checks++;
            if ({bus.ser_valid, bus.ser_out, bus.s, bus.ser_last, bus.load_ready} !==
                {1'b1, exp_bits[i], 4'(i), LastOnShift && (i == 15), 1'b0}) begin
                errors++;
                $display("FAIL a5c3 beat %0d {valid,out,s,last,load_ready} got %b want %b", i,
                         {bus.ser_valid, bus.ser_out, bus.s, bus.ser_last, bus.load_ready},
                         {1'b1, exp_bits[i], 4'(i), LastOnShift && (i == 15), 1'b0});
            end
            @(negedge clk);
        end
        check_tail(16'hA5C3, "a5c3");
    endtask

    task automatic test_ready_toggle();
        int          k;
        logic [15:0] w;
        w = 16'h8001;
        k = 0;
        bus.ser_ready = 1'b0;
        load_word(w);
        for (int c = 0; c < 32; c++) begin
            bus.ser_ready = (c % 2) == 1;
            #1;
            checks++;
            if ({bus.ser_valid, bus.ser_out, bus.s, bus.ser_last, bus.din_q} !==
                {1'b1, w[k], 4'(k), LastOnShift && (k == 15), w}) begin
                errors++;
                $display("FAIL toggle cycle %0d beat %0d got %h want %h", c, k,
                         {bus.ser_valid, bus.ser_out, bus.s, bus.ser_last, bus.din_q},
                         {1'b1, w[k], 4'(k), LastOnShift && (k == 15), w});
            end
            if (bus.ser_ready) k++;
            @(negedge clk);
        end
        checks++;
        if (k != 16) begin
            errors++;
            $display("FAIL toggle transfer count got %0d want 16", k);
        end
        check_tail(w, "toggle");
    endtask

    task automatic test_no_overwrite();
        bus.ser_ready = 1'b1;
        load_word(16'h1234);
        bus.load_valid = 1'b1;
        bus.load_data  = 16'hBEEF;
        for (int i = 0; i < 16; i++) begin
            #1;
            checks++;
            if ({bus.load_ready, bus.din_q, bus.ser_out} !== {1'b0, 16'h1234, i == 2 || i == 4 ||
                 i == 5 || i == 9 || i == 12}) begin
                errors++;
                $display("FAIL hold beat %0d {load_ready,din_q,out} got %h want %h", i,
                         {bus.load_ready, bus.din_q, bus.ser_out},
                         {1'b0, 16'h1234, i == 2 || i == 4 || i == 5 || i == 9 || i == 12});
            end
            @(negedge clk);
        end
`ifdef PARITY_EN
        @(negedge clk);
`endif
        #1;
        checks++;
        if ({bus.load_ready, bus.ser_valid, bus.din_q} !== {2'b10, 16'h1234}) begin
            errors++;
            $display("FAIL hold idle {load_ready,valid,din_q} got %h want %h",
                     {bus.load_ready, bus.ser_valid, bus.din_q}, {2'b10, 16'h1234});
        end
        @(negedge clk);
        bus.load_valid = 1'b0;
        #1;
        checks++;
        if ({bus.ser_valid, bus.s, bus.din_q, bus.ser_out} !== {1'b1, 4'h0, 16'hBEEF, 1'b1}) begin
            errors++;
            $display("FAIL hold reload {valid,s,din_q,out} got %h want %h",
                     {bus.ser_valid, bus.s, bus.din_q, bus.ser_out}, {1'b1, 4'h0, 16'hBEEF, 1'b1});
        end
        repeat (16) @(negedge clk);
        check_tail(16'hBEEF, "hold");
    endtask

    task automatic test_reset_mid();
        bus.ser_ready = 1'b1;
        load_word(16'hFFFF);
        repeat (7) @(negedge clk);
        #1;
        checks++;
        if (bus.s !== 4'd7) begin
            errors++;
            $display("FAIL midreset pre s got %0d want 7", bus.s);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.s, bus.ser_valid, bus.load_ready, bus.ser_out, bus.din_q} !==
            {4'h0, 3'b010, 16'h0}) begin
            errors++;
            $display("FAIL midreset state got %h want %h",
                     {bus.s, bus.ser_valid, bus.load_ready, bus.ser_out, bus.din_q},
                     {4'h0, 3'b010, 16'h0});
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        stream_word(16'h00F0, "after_reset");
    endtask

    task automatic test_back_to_back();
        bus.ser_ready = 1'b1;
        load_word(16'h0001);
        repeat (15) @(negedge clk);
`ifdef PARITY_EN
        @(negedge clk);
`endif
        // Final beat of word 1 and new load_valid coincide.
        bus.load_valid = 1'b1;
        bus.load_data  = 16'h8000;
        #1;
        checks++;
        if ({bus.ser_valid, bus.ser_last, bus.load_ready} !== 3'b110) begin
            errors++;
            $display("FAIL b2b final beat {valid,last,load_ready} got %b want 110",
                     {bus.ser_valid, bus.ser_last, bus.load_ready});
        end
        @(negedge clk);
        #1;
        checks++;
        if ({bus.ser_valid, bus.load_ready, bus.din_q} !== {2'b01, 16'h0001}) begin
            errors++;
            $display("FAIL b2b gap {valid,load_ready,din_q} got %h want %h",
                     {bus.ser_valid, bus.load_ready, bus.din_q}, {2'b01, 16'h0001});
        end
        @(negedge clk);
        bus.load_valid = 1'b0;
        #1;
        checks++;
        if ({bus.ser_valid, bus.ser_out, bus.s, bus.din_q} !== {2'b10, 4'h0, 16'h8000}) begin
            errors++;
            $display("FAIL b2b word2 beat1 got %h want %h",
                     {bus.ser_valid, bus.ser_out, bus.s, bus.din_q}, {2'b10, 4'h0, 16'h8000});
        end
        repeat (15) @(negedge clk);
        #1;
        checks++;
        if ({bus.ser_valid, bus.ser_out, bus.s, bus.ser_last} !==
            {2'b11, 4'hF, LastOnShift}) begin
            errors++;
            $display("FAIL b2b word2 beat16 got %b want %b",
                     {bus.ser_valid, bus.ser_out, bus.s, bus.ser_last},
                     {2'b11, 4'hF, LastOnShift});
        end
        @(negedge clk);
        check_tail(16'h8000, "b2b");
    endtask

`ifdef PARITY_EN
    task automatic test_parity();
        stream_word(16'h0007, "parity_0007");
        @(negedge clk);
        stream_word(16'h0003, "parity_0003");
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic_stream();
        @(negedge clk);
        test_ready_toggle();
        @(negedge clk);
        test_no_overwrite();
        @(negedge clk);
        test_reset_mid();
        @(negedge clk);
        test_back_to_back();
`ifdef PARITY_EN
        @(negedge clk);
        test_parity();
`endif
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
